// File: rtl/mmio_bridge.sv
// MMIO bridge: MEM-stage loads/stores in the MMIO window become one-hot device requests.
// Stalls 2+k cycles for a device acking k cycles after request; aborts on timeout or unmapped index.
module mmio_bridge #(
    parameter int         DATA_W   = 32,
    parameter int         N_DEV    = 4,
    parameter int         DEV_LSB  = 8,
    parameter logic [3:0] MMIO_TAG = 4'h4,
    parameter int         TIMEOUT  = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_rd,
    input  logic                    cpu_wr,
    input  logic [31:0]             cpu_addr,
    input  logic [DATA_W-1:0]       cpu_wdata,
    output logic [DATA_W-1:0]       cpu_rdata,
    output logic                    stall,
    output logic                    bus_err,
    output logic [N_DEV-1:0]        dev_req,
    output logic                    dev_we,
    output logic [31:0]             dev_addr,
    output logic [DATA_W-1:0]       dev_wdata,
    input  logic [N_DEV*DATA_W-1:0] dev_rdata,
    input  logic [N_DEV-1:0]        dev_ack
);

    localparam int SEL_W  = $clog2(N_DEV);
    localparam int IDX_W  = (SEL_W > 0) ? SEL_W : 1;
    localparam int HI_LSB = DEV_LSB + SEL_W;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [27:0]      HI_MASK = 28'hFFF_FFFF << HI_LSB;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   timeoutCnt;
    logic [IDX_W-1:0]   latIdx;
    logic [IDX_W-1:0]   reqIdx;
    logic [N_DEV-1:0]   selOneHot;
    logic               mmioAcc;
    logic               unmapped;
    logic               ackHit;
    logic [DATA_W-1:0]  rdSel;

    generate
        if (SEL_W > 0) begin : gIdx
            assign reqIdx = cpu_addr[DEV_LSB +: IDX_W];
        end else begin : gIdxOne
            assign reqIdx = '0;
        end
    endgenerate

    assign mmioAcc  = (cpu_rd | cpu_wr) && (cpu_addr[31:28] == MMIO_TAG);
    assign unmapped = (|(cpu_addr[27:0] & HI_MASK)) || !(int'(reqIdx) < N_DEV);
    // dev_req is one-hot on the latched index, so masking acks with it picks dev_ack[idx].
    assign ackHit   = |(dev_ack & dev_req);
    assign rdSel    = dev_rdata[int'(latIdx)*DATA_W +: DATA_W];
    assign stall    = !rst && (((state == IDLE) && mmioAcc) || (state == REQ));

    always_comb begin
        selOneHot = '0;
        for (int i = 0; i < N_DEV; i++) begin
            selOneHot[i] = (int'(reqIdx) == i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            timeoutCnt <= '0;
            latIdx     <= '0;
            dev_req    <= '0;
            dev_we     <= 1'b0;
            dev_addr   <= '0;
            dev_wdata  <= '0;
            cpu_rdata  <= '0;
            bus_err    <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (mmioAcc) begin
                        dev_addr   <= cpu_addr;
                        dev_wdata  <= cpu_wdata;
                        dev_we     <= cpu_wr;
                        latIdx     <= reqIdx;
                        timeoutCnt <= '0;
                        if (unmapped) begin
                            bus_err <= 1'b1;
                            if (!cpu_wr) cpu_rdata <= '1;
                            state <= DONE;
                        end else begin
                            dev_req <= selOneHot;
                            state   <= REQ;
                        end
                    end
                end
                REQ: begin
                    // An ack arriving on the timeout cycle still completes the access cleanly.
                    if (ackHit) begin
                        if (!dev_we) cpu_rdata <= rdSel;
                        dev_req <= '0;
                        state   <= DONE;
                    end else if (timeoutCnt == CNT_MAX) begin
                        bus_err <= 1'b1;
                        if (!dev_we) cpu_rdata <= '1;
                        dev_req <= '0;
                        state   <= DONE;
                    end else begin
                        timeoutCnt <= timeoutCnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge with default parameters (4 devices, TIMEOUT=15).
module tb_mmio_bridge;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_rd, cpu_wr;
    logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
    logic         stall, bus_err, dev_we;
    logic [3:0]   dev_req, dev_ack;
    logic [31:0]  dev_addr, dev_wdata;
    logic [127:0] dev_rdata;

    int checks   = 0;
    int failures = 0;

    // Per-access observations
    int          stallCyc, reqCyc;
    logic [3:0]  reqSeen;
    logic        stableOk, errAtDone, errAtStart, done;
    logic [31:0] rdataAtDone;

    mmio_bridge dut (
        .clk(clk), .rst(rst),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .stall(stall), .bus_err(bus_err),
        .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
        .dev_rdata(dev_rdata), .dev_ack(dev_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one access in the IDLE cycle after the call, acks device ackDev in REQ cycle ackAt
    // (0 = first, negative = never) and records what the bridge did until stall falls.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int ackAt, input int ackDev);
        @(posedge clk); #1;
        cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata; dev_ack = 4'b0;
        stallCyc = 0; reqCyc = 0; reqSeen = 4'b0; stableOk = 1'b1;
        errAtDone = 1'bx; errAtStart = 1'bx; done = 1'b0; rdataAtDone = 'x;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                dev_ack = (ackAt >= 0 && c == ackAt + 1) ? 4'(1 << ackDev) : 4'b0;
            end
            @(negedge clk);
            if (c == 0) errAtStart = bus_err;
            if (dev_req != 4'b0) begin
                reqCyc++;
                reqSeen |= dev_req;
                if (dev_addr !== addr || dev_wdata !== wdata || dev_we !== wr) stableOk = 1'b0;
            end
            if (stall) stallCyc++;
            else begin
                done = 1'b1; errAtDone = bus_err; rdataAtDone = cpu_rdata;
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0; dev_ack = '0;
        dev_rdata = {32'hCAFEBABE, 32'h0BADF00D, 32'hDEADBEEF, 32'hA5A50F0F};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_dev_req", {28'b0, dev_req}, 32'd0);
        check("rst_dev_we", {31'b0, dev_we}, 32'd0);
        check("rst_dev_addr", dev_addr, 32'd0);
        check("rst_dev_wdata", dev_wdata, 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_bus_err", {31'b0, bus_err}, 32'd0);

        // Zero-wait load from device 1
        access(1'b1, 1'b0, 32'h4000_0104, 32'h0, 0, 1);
        check("ld0_done", {31'b0, done}, 32'd1);
        check("ld0_stall", stallCyc, 32'd2);
        check("ld0_reqcyc", reqCyc, 32'd1);
        check("ld0_reqbits", {28'b0, reqSeen}, 32'h2);
        check("ld0_rdata", rdataAtDone, 32'hDEAD_BEEF);
        check("ld0_err", {31'b0, errAtDone}, 32'd0);

        // Store to device 3, acked after 5 wait cycles; accepted right after previous DONE
        access(1'b0, 1'b1, 32'h4000_0300, 32'h1234_5678, 5, 3);
        check("st5_done", {31'b0, done}, 32'd1);
        check("st5_stall", stallCyc, 32'd7);
        check("st5_reqcyc", reqCyc, 32'd6);
        check("st5_reqbits", {28'b0, reqSeen}, 32'h8);
        check("st5_stable", {31'b0, stableOk}, 32'd1);
        check("st5_rdata_kept", rdataAtDone, 32'hDEAD_BEEF);
        check("st5_err", {31'b0, errAtDone}, 32'd0);

        // Load from device 2 that never acks
        access(1'b1, 1'b0, 32'h4000_0200, 32'h0, -1, 2);
        check("to_done", {31'b0, done}, 32'd1);
        check("to_reqcyc", reqCyc, 32'd16);
        check("to_stall", stallCyc, 32'd17);
        check("to_reqbits", {28'b0, reqSeen}, 32'h4);
        check("to_err", {31'b0, errAtDone}, 32'd1);
        check("to_rdata", rdataAtDone, 32'hFFFF_FFFF);

        // Ack lands in the last REQ cycle (counter at TIMEOUT): ack wins, rd+wr not both set
        access(1'b1, 1'b0, 32'h4000_0000, 32'h0, 15, 0);
        check("aw_err_pulse_gone", {31'b0, errAtStart}, 32'd0);
        check("aw_stall", stallCyc, 32'd17);
        check("aw_err", {31'b0, errAtDone}, 32'd0);
        check("aw_rdata", rdataAtDone, 32'hA5A5_0F0F);

        // Unmapped: bit 16 set above the index field
        access(1'b1, 1'b0, 32'h4001_0000, 32'h0, -1, 0);
        check("um_stall", stallCyc, 32'd1);
        check("um_reqcyc", reqCyc, 32'd0);
        check("um_err", {31'b0, errAtDone}, 32'd1);
        check("um_rdata", rdataAtDone, 32'hFFFF_FFFF);

        // Non-MMIO load passes through untouched
        access(1'b1, 1'b0, 32'h1000_0000, 32'h0, 0, 0);
        check("nm_stall", stallCyc, 32'd0);
        check("nm_reqcyc", reqCyc, 32'd0);
        check("nm_err", {31'b0, errAtDone}, 32'd0);
        check("nm_rdata", rdataAtDone, 32'hFFFF_FFFF);

        // rd and wr together: write wins; device 2 acks immediately, cpu_rdata untouched
        access(1'b1, 1'b1, 32'h4000_0204, 32'h0000_BEEF, 0, 2);
        check("rw_stable_we", {31'b0, stableOk}, 32'd1);
        check("rw_rdata_kept", rdataAtDone, 32'hFFFF_FFFF);

        // Reset during the third REQ cycle of an unacked load from device 0
        @(posedge clk); #1;
        cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h4000_0000; dev_ack = 4'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1; cpu_rd = 1'b0;
        @(negedge clk);
        check("rr_req_before", {28'b0, dev_req}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b0; dev_ack = 4'b0001;
        @(negedge clk);
        check("rr_dev_req", {28'b0, dev_req}, 32'd0);
        check("rr_stall", {31'b0, stall}, 32'd0);
        check("rr_bus_err", {31'b0, bus_err}, 32'd0);
        check("rr_cpu_rdata", cpu_rdata, 32'd0);
        @(posedge clk); #1;
        dev_ack = 4'b0;
        @(negedge clk);
        check("rr_spurious_req", {28'b0, dev_req}, 32'd0);
        check("rr_spurious_rdata", cpu_rdata, 32'd0);
        check("rr_spurious_err", {31'b0, bus_err}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
